// File: rtl/sync_timing_detector.sv
// rtl/sync_timing_detector.sv - VGA sync timing measurement, position recovery and lock detection
module sync_timing_detector #(
    parameter int CW          = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_h_sync,
    input  logic          vga_v_sync,
    output logic [CW-1:0] line_clocks,
    output logic [CW-1:0] hsync_width,
    output logic [CW-1:0] frame_lines,
    output logic [CW-1:0] vsync_lines,
    output logic          h_polarity,
    output logic          v_polarity,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          frame_valid,
    output logic          locked,
    output logic          no_signal
);
    localparam int            MW       = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam int            TW       = 4 * CW + 2;
    localparam logic [CW-1:0] MAX      = '1;
    localparam logic [MW-1:0] LOCK_CNT = MW'(LOCK_FRAMES);

    logic          h_s1_q, h_s2_q, h_s3_q, v_s1_q, v_s2_q;
    logic          v_samp_q, v_samp_d;
    logic [CW-1:0] hc_q, hc_d, lc_q, lc_d, hl_q, hl_d, ll_q, ll_d;
    logic          h_armed_q, h_armed_d, v_armed_q, v_armed_d;
    logic          no_sig_q, no_sig_d;
    logic [CW-1:0] line_q, line_d, hw_q, hw_d, fl_q, fl_d, vl_q, vl_d;
    logic          hpol_q, hpol_d, vpol_q, vpol_d;
    logic          fv_q, fv_d;
    logic [TW-1:0] tuple_q, tuple_d, tuple_new;
    logic          tuple_vld_q, tuple_vld_d;
    logic [MW-1:0] match_q, match_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          y_pend_q, y_pend_d;

    logic h_rise, h_fall, h_lead, v_act_start;

    // h_s3_q is the edge-detect register: strobes are acted on at the third clk edge after an input edge
    assign h_rise      = h_s2_q & ~h_s3_q;
    assign h_fall      = ~h_s2_q & h_s3_q;
    assign h_lead      = hpol_q ? h_rise : h_fall;
    // V is only looked at on H rising strobes; active phase starts when the sample first matches polarity
    assign v_act_start = h_rise && (v_s2_q == vpol_q) && (v_samp_q != vpol_q);

    // Next-state logic: line/frame measurement, stuck-H detection, lock tracking and position counters
    always_comb begin
        hc_d        = hc_q;
        lc_d        = lc_q;
        h_armed_d   = h_armed_q;
        no_sig_d    = no_sig_q;
        line_d      = line_q;
        hw_d        = hw_q;
        hpol_d      = hpol_q;
        v_samp_d    = v_samp_q;
        hl_d        = hl_q;
        ll_d        = ll_q;
        v_armed_d   = v_armed_q;
        fl_d        = fl_q;
        vl_d        = vl_q;
        vpol_d      = vpol_q;
        fv_d        = 1'b0;
        tuple_d     = tuple_q;
        tuple_vld_d = tuple_vld_q;
        match_d     = match_q;
        locked_d    = locked_q;
        x_d         = x_q;
        y_d         = y_q;
        y_pend_d    = y_pend_q;
        tuple_new   = '0;

        // The rising-strobe cycle itself is the first high clock of the new line
        if (h_rise) begin
            hc_d      = CW'(1);
            lc_d      = '0;
            h_armed_d = 1'b1;
            no_sig_d  = 1'b0;
            // The first rise after reset or a stuck H only starts counting
            if (h_armed_q) begin
                line_d = hc_q + lc_q;
                hpol_d = (hc_q <= lc_q);
                hw_d   = (hc_q <= lc_q) ? hc_q : lc_q;
            end
        end else begin
            if (h_s2_q) begin
                hc_d = (hc_q == MAX) ? MAX : hc_q + 1'b1;
            end else begin
                lc_d = (lc_q == MAX) ? MAX : lc_q + 1'b1;
            end
            if ((hc_d == MAX) || (lc_d == MAX)) begin
                no_sig_d    = 1'b1;
                h_armed_d   = 1'b0;
                v_armed_d   = 1'b0;
                tuple_vld_d = 1'b0;
                match_d     = '0;
                locked_d    = 1'b0;
            end
        end

        if (h_rise) begin
            v_samp_d = v_s2_q;
            if (v_s2_q && !v_samp_q) begin
                hl_d      = CW'(1);
                ll_d      = '0;
                v_armed_d = 1'b1;
                if (v_armed_q) begin
                    fl_d   = hl_q + ll_q;
                    vpol_d = (hl_q <= ll_q);
                    vl_d   = (hl_q <= ll_q) ? hl_q : ll_q;
                    fv_d   = 1'b1;
                end
            end else if (v_s2_q) begin
                hl_d = (hl_q == MAX) ? MAX : hl_q + 1'b1;
            end else begin
                ll_d = (ll_q == MAX) ? MAX : ll_q + 1'b1;
            end
        end

        if (fv_d) begin
            tuple_new   = {line_d, hw_d, hpol_d, fl_d, vl_d, vpol_d};
            tuple_d     = tuple_new;
            tuple_vld_d = 1'b1;
            if (tuple_vld_q && (tuple_new == tuple_q)) begin
                match_d  = (match_q == LOCK_CNT) ? LOCK_CNT : match_q + 1'b1;
                locked_d = (match_d == LOCK_CNT);
            end else begin
                match_d  = '0;
                locked_d = 1'b0;
            end
        end

        if (h_lead) begin
            x_d = '0;
        end else begin
            x_d = (x_q == MAX) ? MAX : x_q + 1'b1;
        end

        if (h_lead) begin
            y_pend_d = 1'b0;
            if (y_pend_q || v_act_start) begin
                y_d = '0;
            end else begin
                y_d = (y_q == MAX) ? MAX : y_q + 1'b1;
            end
        end else if (v_act_start) begin
            y_pend_d = 1'b1;
        end
    end

    // State registers and sync-input synchronizers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_s1_q      <= 1'b0;
            h_s2_q      <= 1'b0;
            h_s3_q      <= 1'b0;
            v_s1_q      <= 1'b0;
            v_s2_q      <= 1'b0;
            v_samp_q    <= 1'b0;
            hc_q        <= '0;
            lc_q        <= '0;
            hl_q        <= '0;
            ll_q        <= '0;
            h_armed_q   <= 1'b0;
            v_armed_q   <= 1'b0;
            no_sig_q    <= 1'b0;
            line_q      <= '0;
            hw_q        <= '0;
            hpol_q      <= 1'b0;
            fl_q        <= '0;
            vl_q        <= '0;
            vpol_q      <= 1'b0;
            fv_q        <= 1'b0;
            tuple_q     <= '0;
            tuple_vld_q <= 1'b0;
            match_q     <= '0;
            locked_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            y_pend_q    <= 1'b0;
        end else begin
            h_s1_q      <= vga_h_sync;
            h_s2_q      <= h_s1_q;
            h_s3_q      <= h_s2_q;
            v_s1_q      <= vga_v_sync;
            v_s2_q      <= v_s1_q;
            v_samp_q    <= v_samp_d;
            hc_q        <= hc_d;
            lc_q        <= lc_d;
            hl_q        <= hl_d;
            ll_q        <= ll_d;
            h_armed_q   <= h_armed_d;
            v_armed_q   <= v_armed_d;
            no_sig_q    <= no_sig_d;
            line_q      <= line_d;
            hw_q        <= hw_d;
            hpol_q      <= hpol_d;
            fl_q        <= fl_d;
            vl_q        <= vl_d;
            vpol_q      <= vpol_d;
            fv_q        <= fv_d;
            tuple_q     <= tuple_d;
            tuple_vld_q <= tuple_vld_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            x_q         <= x_d;
            y_q         <= y_d;
            y_pend_q    <= y_pend_d;
        end
    end

    assign line_clocks = line_q;
    assign hsync_width = hw_q;
    assign frame_lines = fl_q;
    assign vsync_lines = vl_q;
    assign h_polarity  = hpol_q;
    assign v_polarity  = vpol_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign no_signal   = no_sig_q;
endmodule

// File: tb/tb_sync_timing_detector.sv
// tb/tb_sync_timing_detector.sv - scoreboard bench for sync_timing_detector
module tb_sync_timing_detector;
    localparam int CW = 12;
    localparam int LF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          hs;
    logic          vs;
    logic [CW-1:0] line_clocks, hsync_width, frame_lines, vsync_lines, x_pos, y_pos;
    logic          h_polarity, v_polarity, frame_valid, locked, no_signal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int lc; int hw; int hp; int fl; int vl; int vp; int lk;
    } exp_t;
    exp_t exp_q[$];

    sync_timing_detector #(.CW(CW), .LOCK_FRAMES(LF)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_h_sync (hs),
        .vga_v_sync (vs),
        .line_clocks(line_clocks),
        .hsync_width(hsync_width),
        .frame_lines(frame_lines),
        .vsync_lines(vsync_lines),
        .h_polarity (h_polarity),
        .v_polarity (v_polarity),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .frame_valid(frame_valid),
        .locked     (locked),
        .no_signal  (no_signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int lc, input int hw, input int hp, input int fl,
                            input int vl, input int vp, input int lk);
        exp_t e;
        e.lc = lc; e.hw = hw; e.hp = hp; e.fl = fl; e.vl = vl; e.vp = vp; e.lk = lk;
        exp_q.push_back(e);
    endtask

    // One frame: L clocks per line, HW-clock H pulse, N lines, VW-line V pulse starting at line 0
    task automatic drive_frame(input int L, input int HW, input int N, input int VW,
                               input bit hp, input bit vp, input bit xchk, input bit ychk);
        for (int l = 0; l < N; l++) begin
            for (int c = 0; c < L; c++) begin
                @(negedge clk);
                if (xchk && c == 3)  check("x_pos_lead_plus3", int'(x_pos), 0);
                if (xchk && c == 20) check("x_pos_mid_line", int'(x_pos), 17);
                if (ychk && c == 3)  check("y_pos_line", int'(y_pos), l);
                hs = (c < HW) ? hp : ~hp;
                vs = (l < VW) ? vp : ~vp;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_line_clocks"}, int'(line_clocks), 0);
        check({tag, "_hsync_width"}, int'(hsync_width), 0);
        check({tag, "_frame_lines"}, int'(frame_lines), 0);
        check({tag, "_vsync_lines"}, int'(vsync_lines), 0);
        check({tag, "_polarities"},  int'({h_polarity, v_polarity}), 0);
        check({tag, "_xy_pos"},      int'(x_pos) + int'(y_pos), 0);
        check({tag, "_flags"},       int'({frame_valid, locked, no_signal}), 0);
    endtask

    // Monitor: every frame_valid strobe is matched against the next queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && frame_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame_valid: got line_clocks %0d frame_lines %0d with nothing expected",
                         line_clocks, frame_lines);
            end else begin
                e = exp_q.pop_front();
                check("line_clocks", int'(line_clocks), e.lc);
                check("hsync_width", int'(hsync_width), e.hw);
                check("h_polarity",  int'(h_polarity),  e.hp);
                check("frame_lines", int'(frame_lines), e.fl);
                check("vsync_lines", int'(vsync_lines), e.vl);
                check("v_polarity",  int'(v_polarity),  e.vp);
                check("locked",      int'(locked),      e.lk);
            end
        end
    end

    initial begin
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        repeat (4) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Positive syncs, H and V edges on the same clock; lock on the third frame_valid
        drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 1, 1);
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(40, 6, 12, 2, 1, 1, 1, 1);
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(40, 6, 12, 2, 1, 1, 1, 1);

        // One frame with a one-clock-longer line drops lock, then it recovers
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(41, 6, 12, 2, 1, 1, 0, 0);
        push_exp(41, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);

        // H stuck low for 5000 clocks
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i == 3000) check("no_signal_before_sat", int'(no_signal), 0);
            hs = 1'b0;
            vs = 1'b0;
        end
        @(negedge clk);
        check("no_signal_set",      int'(no_signal),   1);
        check("locked_no_signal",   int'(locked),      0);
        check("held_line_clocks",   int'(line_clocks), 40);
        check("held_hsync_width",   int'(hsync_width), 6);
        check("held_frame_lines",   int'(frame_lines), 12);
        check("held_vsync_lines",   int'(vsync_lines), 2);
        drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        check("no_signal_cleared",  int'(no_signal),   0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);

        // Reset mid-frame while locked
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(40, 6, 5, 2, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("midreset");
        rst = 1'b0;
        drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 0); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);
        push_exp(40, 6, 1, 12, 2, 1, 1); drive_frame(40, 6, 12, 2, 1, 1, 0, 0);

        // Both syncs inverted, from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_frame(40, 6, 12, 2, 0, 0, 0, 0);
        push_exp(40, 6, 0, 12, 2, 0, 0); drive_frame(40, 6, 12, 2, 0, 0, 0, 0);
        push_exp(40, 6, 0, 12, 2, 0, 0); drive_frame(40, 6, 12, 2, 0, 0, 1, 0);
        push_exp(40, 6, 0, 12, 2, 0, 1); drive_frame(40, 6, 12, 2, 0, 0, 1, 0);

        repeat (50) @(negedge clk);
        check("pending_frame_valids", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
